uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte-wide first-word-fall-through buffer between the CPU/MMIO UART data register and `tx_uart`. Absorbs bursts of byte writes from the bus side and presents them one at a time to `tx_uart` over its `valid`/`ready` handshake. Also provides occupancy, overrun and drain status for the UART status register and interrupt logic.

## Interface
- `DEPTH`, 16: entries; power of two, ≥ 2.
- `LW`, `$clog2(DEPTH)+1`: width of `level`.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: bus write strobe, one byte per cycle.
- `wr_data` in 8: byte to enqueue.
- `wr_ready` out 1: `!full`.
- `flush` in 1: synchronous clear of all stored entries.
- `clr_overrun` in 1: clears `overrun`.
- `tx_valid` out 1: head entry available; drives `tx_uart.valid`.
- `tx_data` out 8: head byte; drives `tx_uart.tx_data`.
- `tx_ready` in 1: `tx_uart.ready`, a one-cycle pulse at frame completion.
- `level` out LW: stored entry count, 0..DEPTH.
- `empty` out 1: `level == 0`.
- `full` out 1: `level == DEPTH`.
- `overrun` out 1: sticky; a write was dropped.
- `drained` out 1: one-cycle pulse when the last stored byte is popped.

## Operation
- **Storage:** `DEPTH`×8 array.
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is a separate LW-bit counter.
- **push** = `wr_valid & !full`. Writes `mem[wr_ptr]` and increments `wr_ptr`.
- **Write while full:** byte is dropped, and `overrun` is set at the next edge. `overrun` stays set until `clr_overrun` or `reset`. If set and clear occur in the same cycle, set wins.
- **pop** = `tx_ready & !empty`. Increments `rd_ptr`.
  - `tx_ready` while empty is ignored: no pointer change, no underflow.
- **Head output:** `tx_valid = !empty`. `tx_data = mem[rd_ptr]`, a combinational read of registered state.
  - `tx_data` is stable while `tx_valid` is high and no pop occurs.
- **Push and pop in the same cycle:** both take effect and `level` is unchanged.
  - When `level == DEPTH`, push is blocked even if pop is asserted (`wr_ready` depends on `full` only).
- **`level` update:** +1 on push-only, −1 on pop-only, unchanged otherwise.
- **`drained`:** asserted the cycle after a pop that takes `level` from 1 to 0 with no simultaneous push.
- **`flush`:**
  - Sets `wr_ptr`, `rd_ptr` and `level` to 0 at the next edge.
  - Has priority over push and pop in the same cycle; a concurrent write is dropped and does not set `overrun`.
  - Does not generate `drained`.
  - A byte already latched by `tx_uart` still completes on the line. Its later `tx_ready` pulse arrives while empty and is ignored.
- **Head-to-frame behaviour:** the head is popped only on the `tx_ready` pulse of the frame that carried it.
  - The next head is visible the cycle after the pulse.
  - `tx_uart` restarts one cycle later, so back-to-back frames need no gap logic here.
- **Memory contents:** never reset; only pointers and flags are.

## Timing
- **Reset values:** `wr_ptr`=0, `rd_ptr`=0, `level`=0, `overrun`=0, `drained`=0. Hence `tx_valid`=0, `empty`=1, `full`=0, `wr_ready`=1.
  - `tx_data` is undefined until the first push.
- **Reset asserted mid-operation:** all entries are discarded immediately (asynchronous). Outputs take their reset values without waiting for a clock edge.
- **Write-to-transmit latency:** push at edge N gives `tx_valid`=1 after edge N when the FIFO was empty, i.e. one cycle.
- **Pop effect:** `tx_ready` sampled high at edge N advances `tx_data` to the next entry after edge N.
- **Status outputs:** `full`, `empty` and `level` are registered-state derived and valid the cycle after the causing edge.
- **Throughput:**
  - Bus side: 1 byte/cycle until full.
  - Line side: limited only by `tx_uart` frame time.

## Structure
- Shared package `uart_pkg`:
  - `UART_TX_FIFO_DEPTH` default (16).
  - `uart_byte_t` (8-bit) typedef.
  - A `clog2`-based pointer-width constant function.
- One natural sub-module, `uart_fifo_mem`: DEPTH×8 register array with one synchronous write port and one asynchronous read port.
- Pointer, level and flag logic stays in `uart_tx_fifo`.

## Test plan
- **Reset and single byte:** release reset, push 0x41 → `tx_valid`=1 and `tx_data`=0x41 one cycle later. Pulse `tx_ready` → `empty`=1, `drained` pulses once, `level`=0.
- **Fill and ordering:** DEPTH=16, push 0x00..0x0F back-to-back → `full`=1, `wr_ready`=0, `level`=16. Pop 16 times → bytes come out 0x00..0x0F in order, `rd_ptr` wraps, `empty`=1.
- **Overrun:** when full, write 0xAA → byte not stored, `overrun`=1, `level` stays 16. Pulse `clr_overrun` → 0. Set and clear in the same cycle → stays 1.
- **Simultaneous push/pop:** `level`=5, push 0x55 with `tx_ready` high → `level` stays 5, head advances. Repeat at `level`=16 → push rejected, `level` becomes 15.
- **Flush:** `level`=7 with a concurrent write and pop → next cycle `level`=0, no `overrun`, no `drained`. A later stray `tx_ready` → no change.
- **With real `tx_uart` (div=4):** queue "HI\n" → three frames on the line, each starting the cycle after the previous `tx_ready` plus one, then `drained`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Provides the byte type, TX FIFO default depth and pointer-width helper.
package uart_pkg;

  localparam int UART_TX_FIFO_DEPTH = 16;

  typedef logic [7:0] uart_byte_t;

  // Pointer width for a power-of-two depth; never narrower than 1 bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 register array: one synchronous write port, one async read.
// Ports: clk, we_i, waddr_i, wdata_i, raddr_i, rdata_o. Contents never reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH,
  localparam int AW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  uart_byte_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output uart_byte_t    rdata_o
);

  uart_byte_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding tx_uart, with level/overrun/drained status.
// Ports: bus write side (wr_*), flush, clr_overrun, tx handshake (tx_*), status outputs.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  uart_byte_t    wr_data,
  output logic          wr_ready,
  input  logic          flush,
  input  logic          clr_overrun,
  output logic          tx_valid,
  output uart_byte_t    tx_data,
  input  logic          tx_ready,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full,
  output logic          overrun,
  output logic          drained
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overrun_q, overrun_d;
  logic          drained_q, drained_d;

  logic push;
  logic pop;
  logic drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  // Flush wins over both sides; a write dropped by flush is not an overrun.
  assign push = wr_valid & ~full & ~flush;
  assign pop  = tx_ready & ~empty & ~flush;
  assign drop = wr_valid & full & ~flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    drained_d = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case (1'b1)
        push & ~pop: level_d = level_q + LW'(1);
        pop & ~push: level_d = level_q - LW'(1);
        default:     level_d = level_q;
      endcase
      drained_d = pop & ~push & (level_q == LW'(1));
    end

    // Set has priority over clear.
    if (clr_overrun) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      drained_q <= drained_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .raddr_i(rd_ptr_q),
    .rdata_o(tx_data)
  );

  assign wr_ready = ~full;
  assign tx_valid = ~empty;
  assign level    = level_q;
  assign overrun  = overrun_q;
  assign drained  = drained_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16).
// Linear stimulus; immediate assertions count and report failures.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       flush;
  logic       clr_overrun;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       drained;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .clr_overrun(clr_overrun),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .overrun    (overrun),
    .drained    (drained)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pop1();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    wr_valid    = 1'b0;
    wr_data     = 8'h00;
    flush       = 1'b0;
    clr_overrun = 1'b0;
    tx_ready    = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_overrun",  32'(overrun),  32'd0);
    chk("rst_drained",  32'(drained),  32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Single byte
    push1(8'h41);
    chk("one_valid", 32'(tx_valid), 32'd1);
    chk("one_data",  32'(tx_data),  32'h41);
    chk("one_level", 32'(level),    32'd1);
    pop1();
    chk("one_empty",   32'(empty),   32'd1);
    chk("one_level0",  32'(level),   32'd0);
    chk("one_drained", 32'(drained), 32'd1);
    step();
    chk("one_drain_pulse", 32'(drained), 32'd0);

    // tx_ready while empty is ignored
    pop1();
    chk("und_level",   32'(level),    32'd0);
    chk("und_drained", 32'(drained),  32'd0);
    chk("und_valid",   32'(tx_valid), 32'd0);

    // Fill
    for (int i = 0; i < 16; i++) push1(8'(i));
    chk("fill_full",     32'(full),     32'd1);
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    chk("fill_level",    32'(level),    32'd16);
    chk("fill_head",     32'(tx_data),  32'h00);

    // Overrun
    push1(8'hAA);
    chk("ovr_set",   32'(overrun), 32'd1);
    chk("ovr_level", 32'(level),   32'd16);
    clr_overrun = 1'b1;
    step();
    chk("ovr_clr", 32'(overrun), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 8'hAB;
    step();
    wr_valid    = 1'b0;
    clr_overrun = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_clr2", 32'(overrun), 32'd0);

    // Push+pop at full: push blocked
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    tx_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    tx_ready = 1'b0;
    chk("pp_full_level",   32'(level),   32'd15);
    chk("pp_full_overrun", 32'(overrun), 32'd1);
    chk("pp_full_head",    32'(tx_data), 32'h01);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;

    // Drain in order; pointers wrap
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("order_%0d", i), 32'(tx_data), 32'(i));
      pop1();
    end
    chk("drain_empty",   32'(empty),   32'd1);
    chk("drain_drained", 32'(drained), 32'd1);

    // Push+pop at level 5
    for (int i = 0; i < 5; i++) push1(8'h10 + 8'(i));
    chk("l5_level", 32'(level),   32'd5);
    chk("l5_head",  32'(tx_data), 32'h10);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    tx_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    tx_ready = 1'b0;
    chk("pp_level", 32'(level),   32'd5);
    chk("pp_head",  32'(tx_data), 32'h11);

    // Flush at level 7 with concurrent write and pop
    push1(8'h20);
    push1(8'h21);
    chk("fl_pre_level", 32'(level), 32'd7);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    tx_ready = 1'b1;
    step();
    flush    = 1'b0;
    wr_valid = 1'b0;
    tx_ready = 1'b0;
    chk("fl_level",   32'(level),   32'd0);
    chk("fl_empty",   32'(empty),   32'd1);
    chk("fl_overrun", 32'(overrun), 32'd0);
    chk("fl_drained", 32'(drained), 32'd0);
    pop1();
    chk("fl_stray_level",   32'(level),   32'd0);
    chk("fl_stray_drained", 32'(drained), 32'd0);
    push1(8'h5A);
    chk("fl_repush", 32'(tx_data), 32'h5A);

    // Async reset mid-operation
    push1(8'h5B);
    chk("ar_pre", 32'(level), 32'd2);
    reset = 1'b1;
    #1;
    chk("ar_level", 32'(level),    32'd0);
    chk("ar_valid", 32'(tx_valid), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Frame-paced pops: "HI\n" with tx_ready pulses spaced like frames
    push1(8'h48);
    push1(8'h49);
    push1(8'h0A);
    chk("hi_0", 32'(tx_data), 32'h48);
    repeat (6) step();
    pop1();
    chk("hi_1", 32'(tx_data), 32'h49);
    repeat (6) step();
    pop1();
    chk("hi_2", 32'(tx_data), 32'h0A);
    chk("hi_nodrain", 32'(drained), 32'd0);
    repeat (6) step();
    pop1();
    chk("hi_drained", 32'(drained), 32'd1);
    chk("hi_empty",   32'(empty),   32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
